// File: rtl/vga_timing_pkg.sv
// Shared VGA raster timing constants and helpers.
// Renderers import the active-area bounds from here.
package vga_timing_pkg;

    localparam int VGA_CNT_W    = 10;
    localparam int VGA_CNT_MAX  = 1 << VGA_CNT_W;

    localparam int VGA_CLK_DIV  = 2;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam logic VGA_SYNC_POL = 1'b0;

    // Total period of one axis from its four segments.
    function automatic int vga_total(
        input int active,
        input int fp,
        input int sync,
        input int bp
    );
        return active + fp + sync + bp;
    endfunction

    localparam int VGA_H_TOTAL =
        vga_total(VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);
    localparam int VGA_V_TOTAL =
        vga_total(VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);

endpackage

// File: rtl/vga_sync_gen_pixel_tick_gen.sv
// Pixel-enable divider: pixel_tick marks the last
// system clock of every CLK_DIV-clock pixel period.
module pixel_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    output logic pixel_tick
);

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

    logic [3:0] div_q;
    logic [3:0] div_d;
    logic       last;

    // Divider next state: count 0..CLK_DIV-1 and wrap.
    always_comb begin
        last  = (div_q == DIV_LAST);
        div_d = last ? 4'd0 : div_q + 4'd1;
        if (rst) begin
            div_d = 4'd0;
        end
    end

    // Divider register.
    always_ff @(posedge clk) begin
        div_q <= div_d;
    end

    assign pixel_tick = last && !rst;

endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing generator: pixel counters, sync and
// blanking decode, frame-start strobe for game logic.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int   CLK_DIV  = VGA_CLK_DIV,
    parameter int   H_ACTIVE = VGA_H_ACTIVE,
    parameter int   H_FP     = VGA_H_FP,
    parameter int   H_SYNC   = VGA_H_SYNC,
    parameter int   H_BP     = VGA_H_BP,
    parameter int   V_ACTIVE = VGA_V_ACTIVE,
    parameter int   V_FP     = VGA_V_FP,
    parameter int   V_SYNC   = VGA_V_SYNC,
    parameter int   V_BP     = VGA_V_BP,
    parameter logic SYNC_POL = VGA_SYNC_POL
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] HCount,
    output logic [9:0] VCount,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       pixel_tick,
    output logic       frame_start
);

    localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    if (H_TOTAL > VGA_CNT_MAX || V_TOTAL > VGA_CNT_MAX) begin : g_bad_total
        $error("vga_sync_gen: line or frame total exceeds 1024");
    end

    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
        $error("vga_sync_gen: CLK_DIV outside 1..16");
    end

    logic [9:0] hcount_q;
    logic [9:0] hcount_d;
    logic [9:0] vcount_q;
    logic [9:0] vcount_d;
    logic       hsync_q;
    logic       hsync_d;
    logic       vsync_q;
    logic       vsync_d;
    logic       video_on_q;
    logic       video_on_d;
    logic       frame_start_q;
    logic       frame_start_d;
    logic       tick;
    int         h_next;
    int         v_next;

    pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk        (clk),
        .rst        (rst),
        .pixel_tick (tick)
    );

    // Counter advance and decode of the values the counters take next.
    always_comb begin
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        frame_start_d = 1'b0;

        if (rst) begin
            hcount_d = 10'd0;
            vcount_d = 10'd0;
        end else if (tick) begin
            if (hcount_q == H_LAST) begin
                hcount_d = 10'd0;
                if (vcount_q == V_LAST) begin
                    vcount_d      = 10'd0;
                    frame_start_d = 1'b1;
                end else begin
                    vcount_d = vcount_q + 10'd1;
                end
            end else begin
                hcount_d = hcount_q + 10'd1;
            end
        end

        h_next = int'(hcount_d);
        v_next = int'(vcount_d);

        hsync_d = ~SYNC_POL;
        vsync_d = ~SYNC_POL;
        if (!rst && h_next >= HS_START && h_next < HS_END) begin
            hsync_d = SYNC_POL;
        end
        if (!rst && v_next >= VS_START && v_next < VS_END) begin
            vsync_d = SYNC_POL;
        end

        video_on_d = !rst && (h_next < H_ACTIVE) && (v_next < V_ACTIVE);
    end

    // Raster state registers.
    always_ff @(posedge clk) begin
        hcount_q      <= hcount_d;
        vcount_q      <= vcount_d;
        hsync_q       <= hsync_d;
        vsync_q       <= vsync_d;
        video_on_q    <= video_on_d;
        frame_start_q <= frame_start_d;
    end

    assign HCount      = hcount_q;
    assign VCount      = vcount_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign pixel_tick  = tick;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: default 640x480 timing
// plus two reduced rasters (CLK_DIV=2 and CLK_DIV=1, active-high).
module tb_vga_sync_gen;

    logic       clk;
    logic       rst;
    logic [9:0] hc [3];
    logic [9:0] vc [3];
    logic       hs [3];
    logic       vs [3];
    logic       von [3];
    logic       tk [3];
    logic       fs [3];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fs_cnt [3];

    typedef struct {
        int k;
        int id;
        int h;
        int v;
        int hs;
        int vs;
        int von;
        int tk;
        int fs;
    } exp_t;

    exp_t sb [$];

    // Default timing, 800x525, CLK_DIV=2, active-low syncs.
    vga_sync_gen u_a (
        .clk(clk), .rst(rst), .HCount(hc[0]), .VCount(vc[0]),
        .hsync(hs[0]), .vsync(vs[0]), .video_on(von[0]),
        .pixel_tick(tk[0]), .frame_start(fs[0])
    );

    // Reduced 14x10 raster, CLK_DIV=2, active-low.
    vga_sync_gen #(
        .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)
    ) u_b (
        .clk(clk), .rst(rst), .HCount(hc[1]), .VCount(vc[1]),
        .hsync(hs[1]), .vsync(vs[1]), .video_on(von[1]),
        .pixel_tick(tk[1]), .frame_start(fs[1])
    );

    // Reduced 14x10 raster, CLK_DIV=1, active-high.
    vga_sync_gen #(
        .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1)
    ) u_c (
        .clk(clk), .rst(rst), .HCount(hc[2]), .VCount(vc[2]),
        .hsync(hs[2]), .vsync(vs[2]), .video_on(von[2]),
        .pixel_tick(tk[2]), .frame_start(fs[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else cyc <= cyc + 1;
    end

    task automatic chk(string n, int id, int k,
                       logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d k=%0d got=%0d want=%0d",
                     n, id, k, act, exp);
        end
    endtask

    task automatic push(int k, int id, int h, int v, int hs_e,
                        int vs_e, int von_e, int tk_e, int fs_e);
        exp_t e;
        e = '{k, id, h, v, hs_e, vs_e, von_e, tk_e, fs_e};
        sb.push_back(e);
    endtask

    task automatic push_reset();
        push(-1, 0, 0, 0, 1, 1, 0, 0, 0);
        push(-1, 1, 0, 0, 1, 1, 0, 0, 0);
        push(-1, 2, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: sample mid-cycle, pop and compare entries due now.
    initial begin
        int cur;
        exp_t e;
        forever begin
            @(negedge clk);
            cur = rst ? -1 : cyc;
            if (!rst) begin
                for (int i = 0; i < 3; i++)
                    if (fs[i] === 1'b1) fs_cnt[i]++;
            end
            while (sb.size() > 0 &&
                   (sb[0].k == cur ||
                    (sb[0].k >= 0 && cur >= 0 && sb[0].k < cur))) begin
                e = sb.pop_front();
                if (e.k != cur) begin
                    chk("missed", e.id, e.k, cur, e.k);
                end else begin
                    chk("HCount", e.id, cur, 32'(hc[e.id]), e.h);
                    chk("VCount", e.id, cur, 32'(vc[e.id]), e.v);
                    chk("hsync", e.id, cur, 32'(hs[e.id]), e.hs);
                    chk("vsync", e.id, cur, 32'(vs[e.id]), e.vs);
                    chk("video_on", e.id, cur, 32'(von[e.id]), e.von);
                    chk("pixel_tick", e.id, cur, 32'(tk[e.id]), e.tk);
                    chk("frame_start", e.id, cur, 32'(fs[e.id]), e.fs);
                end
            end
        end
    end

    task automatic wait_cyc(int t);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((rst || cyc != t) && n < 5000);
        chk("wait", 0, t, cyc, t);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 3; i++) fs_cnt[i] = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (1234) @(posedge clk);
        #1 rst = 1'b1;
        repeat (5) @(posedge clk);
        push_reset();
        @(negedge clk);
        @(posedge clk);

        push(0, 0, 0, 0, 1, 1, 0, 0, 0);
        push(0, 2, 0, 0, 0, 0, 0, 1, 0);
        push(1, 0, 0, 0, 1, 1, 1, 1, 0);
        push(1, 2, 1, 0, 0, 0, 1, 1, 0);
        push(2, 0, 1, 0, 1, 1, 1, 0, 0);
        push(3, 0, 1, 0, 1, 1, 1, 1, 0);
        push(4, 0, 2, 0, 1, 1, 1, 0, 0);
        push(9, 2, 9, 0, 0, 0, 0, 1, 0);
        push(10, 2, 10, 0, 1, 0, 0, 1, 0);
        push(12, 2, 12, 0, 1, 0, 0, 1, 0);
        push(13, 2, 13, 0, 0, 0, 0, 1, 0);
        push(15, 1, 7, 0, 1, 1, 1, 1, 0);
        push(16, 1, 8, 0, 1, 1, 0, 0, 0);
        push(98, 2, 0, 7, 0, 1, 0, 1, 0);
        push(139, 2, 13, 9, 0, 0, 0, 1, 0);
        push(140, 2, 0, 0, 0, 0, 1, 1, 1);
        push(141, 2, 1, 0, 0, 0, 1, 1, 0);
        push(168, 1, 0, 6, 1, 1, 0, 0, 0);
        push(195, 1, 13, 6, 1, 1, 0, 1, 0);
        push(196, 1, 0, 7, 1, 0, 0, 0, 0);
        push(251, 1, 13, 8, 1, 0, 0, 1, 0);
        push(252, 1, 0, 9, 1, 1, 0, 0, 0);
        push(279, 1, 13, 9, 1, 1, 0, 1, 0);
        push(280, 1, 0, 0, 1, 1, 1, 0, 1);
        push(281, 1, 0, 0, 1, 1, 1, 1, 0);
        push(560, 1, 0, 0, 1, 1, 1, 0, 1);
        push(1279, 0, 639, 0, 1, 1, 1, 1, 0);
        push(1280, 0, 640, 0, 1, 1, 0, 0, 0);
        push(1310, 0, 655, 0, 1, 1, 0, 0, 0);
        push(1312, 0, 656, 0, 0, 1, 0, 0, 0);
        push(1503, 0, 751, 0, 0, 1, 0, 1, 0);
        push(1504, 0, 752, 0, 1, 1, 0, 0, 0);
        push(1599, 0, 799, 0, 1, 1, 0, 1, 0);
        push(1600, 0, 0, 1, 1, 1, 1, 0, 0);
        push(1898, 0, 149, 1, 1, 1, 1, 0, 0);
        push(1898, 1, 11, 7, 0, 0, 0, 0, 0);
        push(1898, 2, 8, 5, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) fs_cnt[i] = 0;
        #1 rst = 1'b0;

        wait_cyc(1700);
        #1;
        chk("frame_count", 0, 1700, fs_cnt[0], 0);
        chk("frame_count", 1, 1700, fs_cnt[1], 6);
        chk("frame_count", 2, 1700, fs_cnt[2], 12);

        wait_cyc(1898);
        #1;
        push_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        push(0, 1, 0, 0, 1, 1, 0, 0, 0);
        push(1, 0, 0, 0, 1, 1, 1, 1, 0);
        push(1, 1, 0, 0, 1, 1, 1, 1, 0);
        push(20, 1, 10, 0, 0, 1, 0, 0, 0);
        push(140, 2, 0, 0, 0, 0, 1, 1, 1);
        #1 rst = 1'b0;

        n = 0;
        while (sb.size() > 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("sb_drain", 0, cyc, sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
